// File: rtl/stw_seq_pkg.sv
// STW test sequencer shared types and constants.
// Provides the FSM state enum, fixed test vectors and LFSR defaults.
package stw_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_CAPTURE,
      S_NEXT,
      S_FINISH
   } state_e;

   localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;
   localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;
   localparam int          NUM_FIXED_VEC = 4;

   // Fixed vectors are built 64 bits wide and cut to ws bits by the caller.
   function automatic logic [63:0] ones_w(input int ws);
      return (ws >= 64) ? '1 : ((64'd1 << ws) - 64'd1);
   endfunction

   function automatic logic [63:0] fixed_op1(input int idx, input int ws);
      logic [63:0] v;
      case (idx)
         1:       v = ones_w(ws);
         2:       v = 64'h5555_5555_5555_5555 & ones_w(ws);
         3:       v = 64'd2;
         default: v = '0;
      endcase
      return v;
   endfunction

   function automatic logic [63:0] fixed_op2(input int idx, input int ws);
      logic [63:0] v;
      case (idx)
         1, 2:    v = 64'd1;
         3:       v = 64'd2 & ones_w(ws);
         default: v = '0;
      endcase
      return v;
   endfunction

   function automatic logic [63:0] fixed_add(input int idx, input int ws);
      logic [63:0] v;
      case (idx)
         2:       v = 64'hAAAA_AAAA_AAAA_AAAA & ones_w(ws);
         3:       v = ones_w(ws);
         default: v = '0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/stw_test_sequencer_lfsr.sv
// Galois LFSR used for the pseudo-random STW vectors.
// Ports: clk, rst (sync, high), load (to SEED), step, q (state), nxt (next).
module stw_lfsr #(
   parameter int                   WORD_SIZE = 16,
   parameter logic [WORD_SIZE-1:0] SEED      = '1,
   parameter logic [WORD_SIZE-1:0] TAPS      = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 step,
   output logic [WORD_SIZE-1:0] q,
   output logic [WORD_SIZE-1:0] nxt
);

   logic [WORD_SIZE-1:0] lfsr_q, lfsr_d;

   assign nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
   assign q   = lfsr_q;

   always_comb begin
      lfsr_d = lfsr_q;
      if (load)      lfsr_d = SEED;
      else if (step) lfsr_d = nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= SEED;
      else     lfsr_q <= lfsr_d;
   end

endmodule

// File: rtl/stw_test_sequencer.sv
// Applies fixed and LFSR STW vectors to NUM_PE PEs and builds a fault map.
// Ports: clk/rst, test_req/pe_mask in, busy/done status, stw_* vector and
// handshake bus to the PEs, fault_map/fault_any/timeout_err results.
module stw_test_sequencer
   import stw_seq_pkg::*;
#(
   parameter int          WORD_SIZE      = 16,
   parameter int          NUM_PE         = 4,
   parameter int          NUM_LFSR_VEC   = 4,
   parameter logic [15:0] LFSR_SEED      = DEF_LFSR_SEED,
   parameter logic [15:0] LFSR_TAPS      = DEF_LFSR_TAPS,
   parameter int          TIMEOUT_CYCLES = 15
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 test_req,
   input  logic [NUM_PE-1:0]    pe_mask,
   output logic                 busy,
   output logic                 done,
   output logic                 stw_test_load_en,
   output logic [WORD_SIZE-1:0] stw_mult_op1,
   output logic [WORD_SIZE-1:0] stw_mult_op2,
   output logic [WORD_SIZE-1:0] stw_add_op,
   output logic [WORD_SIZE-1:0] stw_expected,
   output logic [NUM_PE-1:0]    stw_start,
   input  logic [NUM_PE-1:0]    stw_complete_in,
   input  logic [NUM_PE-1:0]    stw_result_in,
   output logic [NUM_PE-1:0]    fault_map,
   output logic                 fault_any,
   output logic                 timeout_err
);

   localparam int W       = WORD_SIZE;
   localparam int NUM_VEC = NUM_FIXED_VEC + NUM_LFSR_VEC;
   localparam int VW      = $clog2(NUM_VEC);
   localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

   state_e            state_q, state_d;
   logic [VW-1:0]     vec_q, vec_d, nidx;
   logic [TW-1:0]     timer_q, timer_d;
   logic [NUM_PE-1:0] mask_q, mask_d;
   logic [NUM_PE-1:0] ack_q, ack_d;
   logic [NUM_PE-1:0] fault_q, fault_d;
   logic [NUM_PE-1:0] start_q, start_d;
   logic              fault_any_q, fault_any_d;
   logic              terr_q, terr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              load_q, load_d;
   logic [W-1:0]      op1_q, op1_d;
   logic [W-1:0]      op2_q, op2_d;
   logic [W-1:0]      add_q, add_d;
   logic [W-1:0]      lfsr_q, lfsr_nxt, lval;
   logic              lfsr_load, lfsr_step;
   logic              timed_out;

   stw_lfsr #(
      .WORD_SIZE (W),
      .SEED      (W'(LFSR_SEED)),
      .TAPS      (W'(LFSR_TAPS))
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (lfsr_load),
      .step (lfsr_step),
      .q    (lfsr_q),
      .nxt  (lfsr_nxt)
   );

   assign timed_out = (timer_q == TW'(TIMEOUT_CYCLES));

   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      timer_d   = timer_q;
      mask_d    = mask_q;
      ack_d     = ack_q;
      fault_d   = fault_q;
      terr_d    = terr_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      load_d    = 1'b0;
      start_d   = '0;
      op1_d     = op1_q;
      op2_d     = op2_q;
      add_d     = add_q;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      nidx      = vec_q + VW'(1);
      // The vector after an LFSR vector uses the stepped value.
      lval = (int'(vec_q) >= NUM_FIXED_VEC) ? lfsr_nxt : lfsr_q;

      unique case (state_q)
         S_IDLE: begin
            if (test_req) begin
               mask_d    = pe_mask;
               fault_d   = '0;
               terr_d    = 1'b0;
               vec_d     = '0;
               lfsr_load = 1'b1;
               if (pe_mask == '0) begin
                  done_d  = 1'b1;
                  state_d = S_FINISH;
               end else begin
                  busy_d  = 1'b1;
                  load_d  = 1'b1;
                  op1_d   = W'(fixed_op1(0, W));
                  op2_d   = W'(fixed_op2(0, W));
                  add_d   = W'(fixed_add(0, W));
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            start_d = mask_q;
            state_d = S_START;
         end
         S_START: begin
            timer_d = '0;
            ack_d   = '0;
            state_d = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            // Remember each ack so a PE that already went high
            // again is not blamed when a sibling times out.
            ack_d = ack_q | (mask_q & ~stw_complete_in);
            if (ack_d == mask_q) begin
               timer_d = '0;
               state_d = S_WAIT_DONE;
            end else if (timed_out) begin
               fault_d = fault_q | (mask_q & ~ack_d);
               terr_d  = 1'b1;
               state_d = S_CAPTURE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_WAIT_DONE: begin
            if ((mask_q & ~stw_complete_in) == '0) begin
               state_d = S_CAPTURE;
            end else if (timed_out) begin
               fault_d = fault_q | (mask_q & ~stw_complete_in);
               terr_d  = 1'b1;
               state_d = S_CAPTURE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_CAPTURE: begin
            fault_d = fault_q | (mask_q & ~stw_result_in);
            state_d = S_NEXT;
         end
         S_NEXT: begin
            if (vec_q == VW'(NUM_VEC - 1)) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_FINISH;
            end else begin
               vec_d     = nidx;
               lfsr_step = (int'(vec_q) >= NUM_FIXED_VEC);
               load_d    = 1'b1;
               state_d   = S_LOAD;
               if (int'(nidx) < NUM_FIXED_VEC) begin
                  op1_d = W'(fixed_op1(int'(nidx), W));
                  op2_d = W'(fixed_op2(int'(nidx), W));
                  add_d = W'(fixed_add(int'(nidx), W));
               end else begin
                  op1_d = lval;
                  op2_d = {lval[W-2:0], lval[W-1]};
                  add_d = ~lval;
               end
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      fault_any_d = |fault_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         vec_q       <= '0;
         timer_q     <= '0;
         mask_q      <= '0;
         ack_q       <= '0;
         fault_q     <= '0;
         fault_any_q <= 1'b0;
         terr_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         load_q      <= 1'b0;
         start_q     <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         add_q       <= '0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         timer_q     <= timer_d;
         mask_q      <= mask_d;
         ack_q       <= ack_d;
         fault_q     <= fault_d;
         fault_any_q <= fault_any_d;
         terr_q      <= terr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         load_q      <= load_d;
         start_q     <= start_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         add_q       <= add_d;
      end
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign stw_test_load_en = load_q;
   assign stw_mult_op1     = op1_q;
   assign stw_mult_op2     = op2_q;
   assign stw_add_op       = add_q;
   assign stw_expected     = op1_q * op2_q + add_q;
   assign stw_start        = start_q;
   assign fault_map        = fault_q;
   assign fault_any        = fault_any_q;
   assign timeout_err      = terr_q;

endmodule

// File: tb/tb_stw_test_sequencer.sv
// Scoreboard bench for stw_test_sequencer with four behavioural STW PEs.
// Ports: drives clk/rst/test_req/pe_mask and the PE handshake inputs.
module tb_stw_test_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        test_req = 1'b0;
   logic [3:0]  pe_mask = '0;
   logic        busy, done, load_en;
   logic [15:0] op1, op2, add_op, expv;
   logic [3:0]  start, comp, res, fmap;
   logic        fany, terr;
   logic [1:0]  cnt [4];

   logic fail_v2  = 1'b0;
   logic fail_pe1 = 1'b0;
   logic stuck1   = 1'b0;

   typedef struct packed {
      logic [15:0] op1;
      logic [15:0] op2;
      logic [15:0] add;
      logic [15:0] exp;
   } vec_t;

   vec_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   logic [15:0] f1 [4] = '{16'h0000, 16'hFFFF, 16'h5555, 16'h0002};
   logic [15:0] f2 [4] = '{16'h0000, 16'h0001, 16'h0001, 16'h0002};
   logic [15:0] fa [4] = '{16'h0000, 16'h0000, 16'hAAAA, 16'hFFFF};

   always #5 clk = ~clk;

   stw_test_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .test_req         (test_req),
      .pe_mask          (pe_mask),
      .busy             (busy),
      .done             (done),
      .stw_test_load_en (load_en),
      .stw_mult_op1     (op1),
      .stw_mult_op2     (op2),
      .stw_add_op       (add_op),
      .stw_expected     (expv),
      .stw_start        (start),
      .stw_complete_in  (comp),
      .stw_result_in    (res),
      .fault_map        (fmap),
      .fault_any        (fany),
      .timeout_err      (terr)
   );

   // PE model: complete drops after start, rises two cycles later.
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rst) begin
            comp[i] <= 1'b1;
            cnt[i]  <= 2'd0;
         end else if (start[i] && !(stuck1 && i == 1)) begin
            comp[i] <= 1'b0;
            cnt[i]  <= 2'd2;
         end else if (cnt[i] == 2'd1) begin
            comp[i] <= 1'b1;
            cnt[i]  <= 2'd0;
         end else if (cnt[i] != 2'd0) begin
            cnt[i]  <= cnt[i] - 2'd1;
         end
      end
   end

   always_comb begin
      res = 4'hF;
      if (fail_pe1) res[1] = 1'b0;
      if (fail_v2 && op1 == 16'h5555) res[2] = 1'b0;
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
   endfunction

   task automatic push_run();
      logic [15:0] l;
      logic [31:0] p;
      vec_t        v;
      l = 16'hACE1;
      for (int i = 0; i < 8; i++) begin
         if (i < 4) begin
            v.op1 = f1[i];
            v.op2 = f2[i];
            v.add = fa[i];
         end else begin
            v.op1 = l;
            v.op2 = {l[14:0], l[15]};
            v.add = ~l;
            l = lfsr_step(l);
         end
         p     = v.op1 * v.op2;
         v.exp = p[15:0] + v.add;
         sb.push_back(v);
      end
   endtask

   task automatic pop_cmp();
      vec_t v;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         v = sb.pop_front();
         check("op1", 32'(op1), 32'(v.op1));
         check("op2", 32'(op2), 32'(v.op2));
         check("add", 32'(add_op), 32'(v.add));
         check("expected", 32'(expv), 32'(v.exp));
      end
   endtask

   task automatic go(input logic [3:0] m);
      @(negedge clk);
      test_req = 1'b1;
      pe_mask  = m;
      @(negedge clk);
      test_req = 1'b0;
   endtask

   // Called on the first negedge after test_req was sampled.
   task automatic wait_done(output int cyc,
                            output logic [3:0] so,
                            output int nld);
      logic got;
      got = 1'b0;
      cyc = 1;
      so  = '0;
      nld = 0;
      for (int k = 0; k < 3000; k++) begin
         if (load_en) begin
            nld++;
            pop_cmp();
         end
         so = so | start;
         if (done) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
         cyc++;
      end
      check("done_seen", 32'(got), 32'd1);
      check("busy_at_done", 32'(busy), 32'd0);
      check("sb_drained", sb.size(), 0);
      @(negedge clk);
      check("done_pulse", 32'(done), 32'd0);
   endtask

   initial begin
      int         cyc, nld;
      logic [3:0] so;

      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_load", 32'(load_en), 32'd0);
      check("rst_op1", 32'(op1), 32'd0);
      check("rst_exp", 32'(expv), 32'd0);
      check("rst_start", 32'(start), 32'd0);
      check("rst_fmap", 32'(fmap), 32'd0);
      check("rst_fany", 32'(fany), 32'd0);
      check("rst_terr", 32'(terr), 32'd0);
      rst = 1'b0;

      // all pass
      push_run();
      go(4'hF);
      check("run_busy", 32'(busy), 32'd1);
      wait_done(cyc, so, nld);
      check("run_cycles", cyc, 57);
      check("run_loads", nld, 8);
      check("pass_fmap", 32'(fmap), 32'h0);
      check("pass_fany", 32'(fany), 32'd0);
      check("pass_terr", 32'(terr), 32'd0);

      // PE2 fails only v2
      fail_v2 = 1'b1;
      push_run();
      go(4'hF);
      wait_done(cyc, so, nld);
      check("v2_fmap", 32'(fmap), 32'h4);
      check("v2_fany", 32'(fany), 32'd1);
      check("v2_terr", 32'(terr), 32'd0);
      fail_v2 = 1'b0;

      // PE1 never acks
      stuck1 = 1'b1;
      push_run();
      go(4'hF);
      wait_done(cyc, so, nld);
      check("to_fmap", 32'(fmap), 32'h2);
      check("to_terr", 32'(terr), 32'd1);
      check("to_loads", nld, 8);
      stuck1 = 1'b0;

      // masked-out failing PE
      fail_pe1 = 1'b1;
      push_run();
      go(4'b0101);
      wait_done(cyc, so, nld);
      check("mask_start", 32'(so), 32'h5);
      check("mask_fmap", 32'(fmap), 32'h0);
      check("mask_terr", 32'(terr), 32'd0);
      fail_pe1 = 1'b0;

      // empty mask
      go(4'h0);
      wait_done(cyc, so, nld);
      check("empty_cycles", cyc, 1);
      check("empty_loads", nld, 0);

      // reset in WAIT_DONE of v5
      push_run();
      go(4'hF);
      nld = 0;
      for (int k = 0; k < 200 && nld < 6; k++) begin
         if (load_en) begin
            nld++;
            pop_cmp();
         end
         if (nld < 6) @(negedge clk);
      end
      check("v5_reached", nld, 6);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_load", 32'(load_en), 32'd0);
      check("mid_op1", 32'(op1), 32'd0);
      check("mid_op2", 32'(op2), 32'd0);
      check("mid_add", 32'(add_op), 32'd0);
      check("mid_exp", 32'(expv), 32'd0);
      check("mid_start", 32'(start), 32'd0);
      check("mid_fmap", 32'(fmap), 32'd0);
      rst = 1'b0;
      sb.delete();
      push_run();
      go(4'hF);
      wait_done(cyc, so, nld);
      check("replay_cycles", cyc, 57);
      check("replay_fmap", 32'(fmap), 32'h0);

      // test_req held: back-to-back runs
      fail_v2 = 1'b1;
      push_run();
      @(negedge clk);
      test_req = 1'b1;
      pe_mask  = 4'hF;
      @(negedge clk);
      wait_done(cyc, so, nld);
      check("held_fmap1", 32'(fmap), 32'h4);
      check("idle_busy", 32'(busy), 32'd0);
      fail_v2 = 1'b0;
      push_run();
      @(negedge clk);
      check("held_busy2", 32'(busy), 32'd1);
      check("held_clear", 32'(fmap), 32'h0);
      check("held_fany", 32'(fany), 32'd0);
      test_req = 1'b0;
      wait_done(cyc, so, nld);
      check("held_cycles", cyc, 57);
      check("held_loads", nld, 8);
      check("held_fmap2", 32'(fmap), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
